scie_fir_issuer: RTL

SCIE_FIR_ISSUER -- requirements
Module: scie_fir_issuer

---
 rtl/scie_fir_issuer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/scie_fir_issuer.sv
// Sequences coefficient loads and sample push/read instructions onto an SCIE accelerator port.
// Latency: 3 + RD_LATENCY cycles from sample handshake to r_valid. Backpressure: holds OUT until r_ready; inputs stall outside IDLE.
// Optional SCIE_FIR_PERF_EN adds perf_samples / perf_cycles counters.
module scie_fir_issuer #(
    parameter int          NTAPS      = 5,
    parameter int          RD_LATENCY = 1,
    parameter logic [31:0] OP_LOAD    = 32'd11,
    parameter logic [31:0] OP_PUSH    = 32'd43,
    parameter logic [31:0] OP_READ    = 32'd91,
    localparam int         IW         = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic [IW-1:0]      coef_idx,
    input  logic signed [31:0] coef_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic signed [31:0] s_data,
    output logic               r_valid,
    input  logic               r_ready,
    output logic signed [31:0] r_data,
    output logic               scie_valid,
    output logic [31:0]        scie_insn,
    output logic [31:0]        scie_rs1,
    output logic [31:0]        scie_rs2,
    input  logic signed [31:0] scie_rd,
    output logic               busy
`ifdef SCIE_FIR_PERF_EN
    ,
    output logic [31:0]        perf_samples,
    output logic [31:0]        perf_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE, LOAD, PUSH, GAP, READ, WAIT, OUT
    } state_t;

    // READ itself covers the first latency cycle, so WAIT only spans the remainder.
    localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

    state_t             state, state_nxt;
    logic [2:0]         wait_cnt;
    logic [IW-1:0]      coef_idx_q;
    logic signed [31:0] coef_data_q;
    logic signed [31:0] sample_q;
    logic signed [31:0] result_q;
    logic               capture;

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        coef_ready = 1'b0;
        s_ready    = 1'b0;
        scie_valid = 1'b0;
        scie_insn  = '0;
        scie_rs1   = '0;
        scie_rs2   = '0;
        case (state)
            IDLE: begin
                coef_ready = 1'b1;
                s_ready    = !coef_valid;
                if (coef_valid)   state_nxt = LOAD;
                else if (s_valid) state_nxt = PUSH;
            end
            LOAD: begin
                scie_valid = 1'b1;
                scie_insn  = OP_LOAD;
                scie_rs1   = coef_data_q;
                scie_rs2   = 32'(coef_idx_q);
                state_nxt  = IDLE;
            end
            PUSH: begin
                scie_valid = 1'b1;
                scie_insn  = OP_PUSH;
                scie_rs1   = sample_q;
                state_nxt  = GAP;
            end
            GAP: state_nxt = READ;
            READ: begin
                scie_valid = 1'b1;
                scie_insn  = OP_READ;
                if (RD_LATENCY == 1) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 3'd1) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: if (r_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            coef_idx_q  <= '0;
            coef_data_q <= '0;
            sample_q    <= '0;
            result_q    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && coef_valid) begin
                coef_idx_q  <= coef_idx;
                coef_data_q <= coef_data;
            end
            if (state == IDLE && !coef_valid && s_valid) sample_q <= s_data;
            if (state == READ)      wait_cnt <= WAIT_INIT;
            else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;
            if (capture) result_q <= scie_rd;
        end
    end

    assign r_valid = (state == OUT);
    assign r_data  = result_q;
    assign busy    = (state != IDLE);

`ifdef SCIE_FIR_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_samples <= '0;
            perf_cycles  <= '0;
        end else begin
            if (r_valid && r_ready) perf_samples <= perf_samples + 32'd1;
            if (busy)               perf_cycles  <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
